// File: rtl/ledpanel_fill.sv
// Bus controller in front of the ledpanel ctrl port: arbitrates host accesses against a
// rectangle-fill engine that issues one single-pixel frame-buffer write per transaction.
module ledpanel_fill #(
    parameter int unsigned SIZE = 1,
    parameter int unsigned XB   = 5 + $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    host_wr,
    input  logic          host_rd,
    input  logic [15:0]   host_addr,
    input  logic [31:0]   host_wdat,
    output logic [31:0]   host_rdat,
    output logic          host_done,
    input  logic          fill_start,
    input  logic [XB-1:0] fill_x0,
    input  logic [XB-1:0] fill_x1,
    input  logic [4:0]    fill_y0,
    input  logic [4:0]    fill_y1,
    input  logic [23:0]   fill_rgb,
    input  logic          fill_abort,
    output logic          fill_busy,
    output logic          fill_done,
    output logic [3:0]    ctrl_wr,
    output logic          ctrl_rd,
    output logic [15:0]   ctrl_addr,
    output logic [31:0]   ctrl_wdat,
    input  logic [31:0]   ctrl_rdat,
    input  logic          ctrl_done
);

    localparam logic [XB-1:0] XMax = XB'(32 * SIZE - 1);

    typedef enum logic [1:0] {StIdle, StHost, StFill} state_e;

    state_e        state_q, state_d;
    logic          last_fill_q;
    logic          host_req, fill_req;
    logic          grant_host, grant_fill;

    logic          busy_q, done_q, abort_q;
    logic [XB-1:0] x_q, x0_q, x1_q;
    logic [4:0]    y_q, y1_q;
    logic [23:0]   rgb_q;

    logic [3:0]    ctrl_wr_q;
    logic          ctrl_rd_q;
    logic [15:0]   ctrl_addr_q;
    logic [31:0]   ctrl_wdat_q;

    logic [XB-1:0] x0_clip, x1_clip;
    logic          start_ok, fill_ack, last_px, finish;

    assign host_rdat = ctrl_rdat;
    assign host_done = ctrl_done && (state_q == StHost);
    assign fill_busy = busy_q;
    assign fill_done = done_q;
    assign ctrl_wr   = ctrl_wr_q;
    assign ctrl_rd   = ctrl_rd_q;
    assign ctrl_addr = ctrl_addr_q;
    assign ctrl_wdat = ctrl_wdat_q;

    assign host_req = (|host_wr) || host_rd;
    // An abort arriving this cycle must already suppress the next fill grant.
    assign fill_req = busy_q && !abort_q && !fill_abort;

    always_comb begin
        state_d    = state_q;
        grant_host = 1'b0;
        grant_fill = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (host_req && (!fill_req || last_fill_q)) begin
                    state_d    = StHost;
                    grant_host = 1'b1;
                end else if (fill_req) begin
                    state_d    = StFill;
                    grant_fill = 1'b1;
                end
            end
            StHost, StFill: begin
                if (ctrl_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            last_fill_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q != StIdle && ctrl_done) last_fill_q <= (state_q == StFill);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_wr_q   <= 4'b0;
            ctrl_rd_q   <= 1'b0;
            ctrl_addr_q <= 16'h0;
            ctrl_wdat_q <= 32'h0;
        end else if (grant_host) begin
            ctrl_wr_q   <= host_wr;
            ctrl_rd_q   <= host_rd;
            ctrl_addr_q <= host_addr;
            ctrl_wdat_q <= host_wdat;
        end else if (grant_fill) begin
            ctrl_wr_q   <= 4'b0111;
            ctrl_rd_q   <= 1'b0;
            ctrl_addr_q <= 16'({x_q, y_q, 2'b00});
            ctrl_wdat_q <= {8'h00, rgb_q};
        end else if (state_q != StIdle && ctrl_done) begin
            ctrl_wr_q <= 4'b0;
            ctrl_rd_q <= 1'b0;
        end
    end

    assign x0_clip  = (fill_x0 > XMax) ? XMax : fill_x0;
    assign x1_clip  = (fill_x1 > XMax) ? XMax : fill_x1;
    assign start_ok = fill_start && !busy_q && (x0_clip <= x1_clip) && (fill_y0 <= fill_y1);
    assign fill_ack = (state_q == StFill) && ctrl_done;
    assign last_px  = (x_q == x1_q) && (y_q == y1_q);
    // With no write in flight an abort ends the command at once; otherwise at its done.
    assign finish   = busy_q && ((fill_ack && (abort_q || fill_abort || last_px)) ||
                                 (fill_abort && state_q != StFill));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            x_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y_q     <= 5'd0;
            y1_q    <= 5'd0;
            rgb_q   <= 24'h0;
        end else begin
            done_q <= finish;
            if (start_ok) begin
                busy_q  <= 1'b1;
                abort_q <= 1'b0;
                x_q     <= x0_clip;
                x0_q    <= x0_clip;
                x1_q    <= x1_clip;
                y_q     <= fill_y0;
                y1_q    <= fill_y1;
                rgb_q   <= fill_rgb;
            end else if (finish) begin
                busy_q  <= 1'b0;
                abort_q <= 1'b0;
            end else begin
                if (busy_q && fill_abort) abort_q <= 1'b1;
                if (fill_ack) begin
                    if (x_q < x1_q) begin
                        x_q <= x_q + 1'b1;
                    end else begin
                        x_q <= x0_q;
                        y_q <= y_q + 1'b1;
                    end
                end
            end
        end
    end

endmodule
